// File: rtl/ex_divider_pkg.sv
// ----------------------------------------------------------------------------
// ex_divider_pkg
//   Shared constants, FSM state type and small arithmetic helpers for the
//   EX-stage radix-2 restoring divider.
//   Contents:
//     DATA_W      operand width (result is 2*DATA_W: {remainder, quotient})
//     DIV_ITER    number of BUSY iterations (one quotient bit per cycle)
//     CNT_W       width of the iteration counter
//     div_state_e IDLE=0, BUSY=1, DONE=2
//     magnitude() absolute value of a two's-complement operand when asked
//     apply_sign() conditional two's-complement negate
// ----------------------------------------------------------------------------
package ex_divider_pkg;

    localparam int DATA_W   = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Magnitude is only taken for signed operations; unsigned operands
    // pass through untouched even when their top bit is set.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                    input logic             is_signed);
        return (is_signed && value[DATA_W-1]) ? -value : value;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] value,
                                                     input logic             negate);
        return negate ? -value : value;
    endfunction

endpackage

// File: rtl/ex_divider_if.sv
// ----------------------------------------------------------------------------
// ex_divider_if
//   Request/response bundle between the EX stage and the divider.
//   master : drives start, signed_op, dividend, divisor, flush;
//            receives stall_req, valid, div_by_zero, div_result
//   slave  : the divider side (mirror directions)
// ----------------------------------------------------------------------------
interface ex_divider_if;
    import ex_divider_pkg::*;

    logic                start;
    logic                signed_op;
    logic [DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic                flush;
    logic                stall_req;
    logic                valid;
    logic                div_by_zero;
    logic [2*DATA_W-1:0] div_result;

    modport master (
        output start, signed_op, dividend, divisor, flush,
        input  stall_req, valid, div_by_zero, div_result
    );

    modport slave (
        input  start, signed_op, dividend, divisor, flush,
        output stall_req, valid, div_by_zero, div_result
    );

endinterface

// File: rtl/ex_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational iteration of a restoring divide.
//   rem_in   partial remainder from the previous iteration (always < divisor)
//   divisor  divisor magnitude
//   next_bit next dividend bit shifted into the partial remainder
//   rem_out  updated partial remainder
//   quo_bit  quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step
    import ex_divider_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] divisor,
    input  logic              next_bit,
    output logic [DATA_W-1:0] rem_out,
    output logic              quo_bit
);

    // The shifted remainder needs one extra bit because it can reach
    // 2*divisor-1; the top bit of the difference is then a clean borrow.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    assign shifted = {rem_in, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign quo_bit = ~diff[DATA_W];
    // On a borrow the shifted value is below the divisor, so it fits DATA_W.
    assign rem_out = quo_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
//   Multi-cycle signed/unsigned 32-bit divider, radix-2 restoring, one
//   quotient bit per cycle. Result is {remainder, quotient} for HI/LO.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    ex_divider_if.slave: start/signed_op/dividend/divisor/flush in,
//          stall_req/valid/div_by_zero/div_result out
// ----------------------------------------------------------------------------
module ex_divider
    import ex_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    ex_divider_if.slave bus
);

    div_state_e          state;
    div_state_e          state_nxt;
    logic [CNT_W-1:0]    counter;
    logic [DATA_W-1:0]   part_rem;
    logic [DATA_W-1:0]   quo_shift;
    logic [DATA_W-1:0]   dvs_mag;
    logic                neg_quo;
    logic                neg_rem;
    logic [2*DATA_W-1:0] result_q;
    logic                dbz_q;

    logic [DATA_W-1:0]   step_rem;
    logic                step_bit;
    logic [DATA_W-1:0]   final_quo;
    logic                accept;
    logic                divisor_zero;
    logic                last_iter;

    assign divisor_zero = (bus.divisor == '0);
    assign accept       = bus.start && !bus.flush && (state != ST_BUSY);
    assign last_iter    = (state == ST_BUSY) && (counter == CNT_W'(DIV_ITER - 1));
    assign final_quo    = {quo_shift[DATA_W-2:0], step_bit};

    // quo_shift doubles as the dividend shift register: its MSB feeds the
    // next iteration while quotient bits enter from the bottom.
    div_step u_step (
        .rem_in   (part_rem),
        .divisor  (dvs_mag),
        .next_bit (quo_shift[DATA_W-1]),
        .rem_out  (step_rem),
        .quo_bit  (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including a new start.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt = divisor_zero ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (last_iter) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state_nxt = divisor_zero ? ST_DONE : ST_BUSY;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: operand capture on an accepted start, one iteration per
    // BUSY cycle, and sign correction folded into the final write-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            part_rem  <= '0;
            quo_shift <= '0;
            dvs_mag   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else if (bus.flush) begin
            counter <= '0;
        end else if (accept) begin
            counter <= '0;
            if (divisor_zero) begin
                result_q <= {bus.dividend, {DATA_W{1'b1}}};
                dbz_q    <= 1'b1;
            end else begin
                part_rem  <= '0;
                quo_shift <= magnitude(bus.dividend, bus.signed_op);
                dvs_mag   <= magnitude(bus.divisor, bus.signed_op);
                neg_quo   <= bus.signed_op && (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
                neg_rem   <= bus.signed_op && bus.dividend[DATA_W-1];
                result_q  <= '0;
                dbz_q     <= 1'b0;
            end
        end else if (state == ST_BUSY) begin
            part_rem  <= step_rem;
            quo_shift <= final_quo;
            counter   <= counter + 1'b1;
            if (last_iter) begin
                result_q <= {apply_sign(step_rem, neg_rem), apply_sign(final_quo, neg_quo)};
            end
        end
    end

    // Stall covers the start cycle of a real divide and every BUSY cycle;
    // a flush drops it in the same cycle.
    assign bus.stall_req   = !bus.flush && ((state == ST_BUSY) || (accept && !divisor_zero));
    assign bus.valid       = (state == ST_DONE);
    assign bus.div_result  = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_divider.sv
// ----------------------------------------------------------------------------
// tb_ex_divider
//   Self-checking bench for ex_divider: a table of directed divides with
//   hand-computed results and latencies, plus hand-written sequences for
//   flush, reset and back-to-back / ignored-start corner cases.
// ----------------------------------------------------------------------------
module tb_ex_divider;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fail_count;

    ex_divider_if bus ();

    ex_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        signed_op;
        logic [31:0] dividend;
        logic [31:0] divisor;
        logic [63:0] exp_result;
        logic        exp_dbz;
        int          exp_latency;
    } vec_t;

    vec_t vectors[$];

    // 10-unit clock period; inputs change 1 unit after the rising edge and
    // outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic addVector(input string name, input logic s_op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_res, input logic exp_dbz,
                             input int exp_lat);
        vec_t v;
        v.name        = name;
        v.signed_op   = s_op;
        v.dividend    = a;
        v.divisor     = b;
        v.exp_result  = exp_res;
        v.exp_dbz     = exp_dbz;
        v.exp_latency = exp_lat;
        vectors.push_back(v);
    endtask

    // Called just after a rising edge. Holds start for one cycle, then waits
    // (bounded) for valid. Returns at the falling edge of the valid cycle.
    task automatic applyStimulus(input logic s_op, input logic [31:0] a,
                                 input logic [31:0] b, output int latency,
                                 output logic [63:0] res, output logic dbz,
                                 output logic start_stall, output int stall_errs);
        bus.start     = 1'b1;
        bus.signed_op = s_op;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        start_stall = bus.stall_req;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        latency    = -1;
        stall_errs = 0;
        res        = '0;
        dbz        = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.valid) begin
                latency = k;
                res     = bus.div_result;
                dbz     = bus.div_by_zero;
                if (bus.stall_req) stall_errs++;
                break;
            end else if (!bus.stall_req) begin
                stall_errs++;
            end
        end
    endtask

    initial begin
        int          latency;
        int          stall_errs;
        int          valid_seen;
        int          stall_seen;
        logic [63:0] res;
        logic        dbz;
        logic        start_stall;

        tests_run  = 0;
        fail_count = 0;

        addVector("divu_100_7",    1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        1'b0, 33);
        addVector("div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
        addVector("div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 1'b0, 33);
        addVector("div_5_0",       1'b1, 32'd5,          32'd0,        {32'd5,        32'hFFFF_FFFF}, 1'b1, 1);
        addVector("div_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 1'b0, 33);
        addVector("divu_ovf_ops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'd0},        1'b0, 33);
        addVector("divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 1'b0, 33);
        addVector("divu_3_10",     1'b0, 32'd3,          32'd10,       {32'd3,        32'd0},         1'b0, 33);
        addVector("div_m100_m7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        1'b0, 33);
        addVector("divu_0_0",      1'b0, 32'd0,          32'd0,        {32'd0,        32'hFFFF_FFFF}, 1'b1, 1);
        addVector("divu_beef_16",  1'b0, 32'hDEAD_BEEF,  32'h10,       {32'hF,        32'h0DEA_DBEE}, 1'b0, 33);
        addVector("div_m5_0",      1'b1, 32'hFFFF_FFFB,  32'd0,        {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 1);
        addVector("divu_equal",    1'b0, 32'h1234_5678,  32'h1234_5678, {32'd0,        32'd1},         1'b0, 33);

        // Reset state.
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid",  bus.valid,       1'b0);
        checkOutput("reset_stall",  bus.stall_req,   1'b0);
        checkOutput("reset_dbz",    bus.div_by_zero, 1'b0);
        checkOutput("reset_result", bus.div_result,  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven divides.
        foreach (vectors[i]) begin
            applyStimulus(vectors[i].signed_op, vectors[i].dividend, vectors[i].divisor,
                          latency, res, dbz, start_stall, stall_errs);
            checkOutput({vectors[i].name, "_latency"},     64'(latency), 64'(vectors[i].exp_latency));
            checkOutput({vectors[i].name, "_result"},      res,          vectors[i].exp_result);
            checkOutput({vectors[i].name, "_dbz"},         dbz,          vectors[i].exp_dbz);
            checkOutput({vectors[i].name, "_start_stall"}, start_stall,  !vectors[i].exp_dbz);
            checkOutput({vectors[i].name, "_busy_stall"},  64'(stall_errs), 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput({vectors[i].name, "_valid_drop"},  bus.valid,      1'b0);
            checkOutput({vectors[i].name, "_hold"},        bus.div_result, vectors[i].exp_result);
            @(posedge clk);
            #1;
        end

        // Flush on the 10th BUSY cycle, then a fresh DIVU 9/3.
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_stall", bus.stall_req, 1'b0);
        checkOutput("flush_valid", bus.valid,     1'b0);
        @(posedge clk);
        #1;
        bus.flush  = 1'b0;
        valid_seen = 0;
        stall_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid) valid_seen++;
            if (bus.stall_req) stall_seen++;
        end
        checkOutput("flush_no_valid", 64'(valid_seen), 64'd0);
        checkOutput("flush_idle",     64'(stall_seen), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'd9, 32'd3, latency, res, dbz, start_stall, stall_errs);
        checkOutput("post_flush_latency", 64'(latency), 64'd33);
        checkOutput("post_flush_result",  res,          {32'd0, 32'd3});
        @(posedge clk);
        #1;

        // Back-to-back: restart in the DONE cycle; a start pulse mid-BUSY is ignored.
        applyStimulus(1'b0, 32'd100, 32'd7, latency, res, dbz, start_stall, stall_errs);
        checkOutput("b2b_first_result", res, {32'd2, 32'd14});
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        #1;
        checkOutput("b2b_restart_stall", bus.stall_req, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        latency   = -1;
        res       = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.valid) begin
                latency = k;
                res     = bus.div_result;
                break;
            end
            if (k == 5) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else if (k == 6) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checkOutput("b2b_second_latency", 64'(latency), 64'd33);
        checkOutput("b2b_second_result",  res,          {32'd0, 32'd3});
        @(posedge clk);
        #1;

        // Reset mid-BUSY: outputs cleared and no valid afterwards.
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy_valid", bus.valid,       1'b0);
        checkOutput("rst_busy_stall", bus.stall_req,   1'b0);
        checkOutput("rst_busy_dbz",   bus.div_by_zero, 1'b0);
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid) valid_seen++;
        end
        checkOutput("rst_busy_no_valid", 64'(valid_seen), 64'd0);
        @(posedge clk);
        #1;

        // Reset clears a held divide-by-zero result.
        applyStimulus(1'b1, 32'd5, 32'd0, latency, res, dbz, start_stall, stall_errs);
        checkOutput("rst_hold_pre_dbz", dbz, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_hold_result", bus.div_result,  64'd0);
        checkOutput("rst_hold_dbz",    bus.div_by_zero, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
